// File: rtl/lcd_seq_display.sv
// HD44780 16x2 LCD driver: power-up wait, init command list, then rewrites
// "SEQ:bbbb" / "DET:YES|NO " whenever {match_in, seq_bits} changes.
module lcd_seq_display #(
  parameter int unsigned PWR_UP_CYC   = 1000000,
  parameter int unsigned E_HIGH_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] seq_bits,
  input  logic       match_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       lcd_ready,
  output logic       busy
);

  function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CNT_MAX = f_max(f_max(PWR_UP_CYC, CLR_WAIT_CYC),
                                          f_max(E_HIGH_CYC, CMD_WAIT_CYC));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t PWR_LAST = cnt_t'(PWR_UP_CYC - 1);
  localparam cnt_t EHI_LAST = cnt_t'(E_HIGH_CYC - 1);
  localparam cnt_t CMD_LAST = cnt_t'(CMD_WAIT_CYC - 1);
  localparam cnt_t CLR_LAST = cnt_t'(CLR_WAIT_CYC - 1);

  typedef enum logic [1:0] {S_PWRUP, S_INIT, S_IDLE, S_UPD} state_t;
  typedef enum logic [1:0] {W_SETUP, W_EHI, W_WAIT} wphase_t;

  state_t     r_state;
  wphase_t    r_phase;
  cnt_t       r_cnt;
  logic [4:0] r_idx;
  logic [4:0] r_snap;
  logic       r_snap_vld;
  logic       r_rs;
  logic       r_e;
  logic [7:0] r_data;
  logic       r_ready;
  logic       r_busy;

  // {rs, data} for each byte of the init list
  function automatic logic [8:0] f_init_byte(input logic [4:0] idx);
    case (idx)
      5'd0, 5'd1, 5'd2, 5'd3: return 9'h038;
      5'd4:                   return 9'h00C;
      5'd5:                   return 9'h001;
      default:                return 9'h006;
    endcase
  endfunction

  // {rs, data} for each byte of a display rewrite; snap = {match, seq[3:0]}
  function automatic logic [8:0] f_upd_byte(input logic [4:0] idx, input logic [4:0] snap);
    case (idx)
      5'd0:    return 9'h080;
      5'd1:    return 9'h153;
      5'd2:    return 9'h145;
      5'd3:    return 9'h151;
      5'd4:    return 9'h13A;
      5'd5:    return {1'b1, 7'h18, snap[0]};
      5'd6:    return {1'b1, 7'h18, snap[1]};
      5'd7:    return {1'b1, 7'h18, snap[2]};
      5'd8:    return {1'b1, 7'h18, snap[3]};
      5'd9:    return 9'h0C0;
      5'd10:   return 9'h144;
      5'd11:   return 9'h145;
      5'd12:   return 9'h154;
      5'd13:   return 9'h13A;
      5'd14:   return snap[4] ? 9'h159 : 9'h14E;
      5'd15:   return snap[4] ? 9'h145 : 9'h14F;
      default: return snap[4] ? 9'h153 : 9'h120;
    endcase
  endfunction

  logic [4:0] w_cur;
  logic [4:0] w_last_idx;
  logic [4:0] w_idx_nxt;
  logic [8:0] w_next_byte;
  cnt_t       w_wait_last;

  assign w_cur       = {match_in, seq_bits};
  assign w_last_idx  = (r_state == S_INIT) ? 5'd6 : 5'd16;
  assign w_idx_nxt   = r_idx + 5'd1;
  assign w_next_byte = (r_state == S_INIT) ? f_init_byte(w_idx_nxt) : f_upd_byte(w_idx_nxt, r_snap);
  assign w_wait_last = (!r_rs && r_data == 8'h01) ? CLR_LAST : CMD_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_PWRUP;
      r_phase    <= W_SETUP;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_snap     <= '0;
      r_snap_vld <= 1'b0;
      r_rs       <= 1'b0;
      r_e        <= 1'b0;
      r_data     <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        S_PWRUP: begin
          if (r_cnt == PWR_LAST) begin
            r_cnt           <= '0;
            r_state         <= S_INIT;
            r_phase         <= W_SETUP;
            r_idx           <= '0;
            {r_rs, r_data}  <= f_init_byte(5'd0);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          // Snapshot is taken on the same edge that presents the first byte
          if (!r_snap_vld || w_cur != r_snap) begin
            r_snap         <= w_cur;
            r_snap_vld     <= 1'b1;
            r_state        <= S_UPD;
            r_busy         <= 1'b1;
            r_phase        <= W_SETUP;
            r_cnt          <= '0;
            r_idx          <= '0;
            {r_rs, r_data} <= f_upd_byte(5'd0, w_cur);
          end
        end
        default: begin
          case (r_phase)
            W_SETUP: begin
              r_e     <= 1'b1;
              r_phase <= W_EHI;
              r_cnt   <= '0;
            end
            W_EHI: begin
              if (r_cnt == EHI_LAST) begin
                r_e     <= 1'b0;
                r_phase <= W_WAIT;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            W_WAIT: begin
              if (r_cnt == w_wait_last) begin
                r_cnt <= '0;
                if (r_idx == w_last_idx) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_rs    <= 1'b0;
                  r_data  <= '0;
                end else begin
                  r_idx          <= w_idx_nxt;
                  r_phase        <= W_SETUP;
                  {r_rs, r_data} <= w_next_byte;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            default: r_phase <= W_SETUP;
          endcase
        end
      endcase
    end
  end

  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = r_e;
  assign lcd_data  = r_data;
  assign lcd_ready = r_ready;
  assign busy      = r_busy;

endmodule

// File: tb/tb_lcd_seq_display.sv
// Directed bench for lcd_seq_display with short timing parameters.
module tb_lcd_seq_display;

  localparam int unsigned PWR = 100;
  localparam int unsigned EH  = 3;
  localparam int unsigned CW  = 10;
  localparam int unsigned CLW = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] seq_bits = 4'b0000;
  logic       match_in = 1'b0;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_ready, busy;
  logic [7:0] lcd_data;

  lcd_seq_display #(
    .PWR_UP_CYC  (PWR),
    .E_HIGH_CYC  (EH),
    .CMD_WAIT_CYC(CW),
    .CLR_WAIT_CYC(CLW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seq_bits (seq_bits),
    .match_in (match_in),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .lcd_ready(lcd_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {rs, data} of update byte i for inputs s / m
  function automatic logic [8:0] upd_byte(input int i, input logic [3:0] s, input logic m);
    string h1, h2, yn;
    h1 = "SEQ:";
    h2 = "DET:";
    yn = m ? "YES" : "NO ";
    if (i == 0)  return 9'h080;
    if (i <= 4)  return {1'b1, h1[i-1]};
    if (i <= 8)  return {1'b1, (s[i-5] ? 8'h31 : 8'h30)};
    if (i == 9)  return 9'h0C0;
    if (i <= 13) return {1'b1, h2[i-10]};
    return {1'b1, yn[i-14]};
  endfunction

  // Waits for the next strobe; returns {rs,data}, rise cycle and high width
  task automatic get_byte(output logic [8:0] rd, output int rise, output int width);
    int n;
    n = 0; rd = '0; rise = cyc; width = 0;
    @(negedge clk);
    while (lcd_e !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (lcd_e !== 1'b1) begin
      check("strobe_timeout", 32'd0, 32'd1);
      return;
    end
    rise = cyc;
    rd   = {lcd_rs, lcd_data};
    while (lcd_e === 1'b1 && width < 100) begin
      if ({lcd_rs, lcd_data} !== rd) check("bus_stable", {lcd_rs, lcd_data}, rd);
      width++;
      @(negedge clk);
    end
  endtask

  task automatic run_init(input int t0, output int last);
    logic [7:0] ini [7];
    logic [8:0] rd;
    int r, w, p;
    ini = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    p = t0;
    for (int i = 0; i < 7; i++) begin
      get_byte(rd, r, w);
      check($sformatf("init_b%0d", i), rd, {1'b0, ini[i]});
      check($sformatf("init_w%0d", i), w, EH);
      if (i == 0)      check("init_first_rise", r - p, PWR + 1);
      else if (i == 6) check("init_gap_clr", r - p, 1 + EH + CLW);
      else             check($sformatf("init_gap%0d", i), r - p, 1 + EH + CW);
      check($sformatf("init_notready%0d", i), lcd_ready, 1'b0);
      p = r;
    end
    last = p;
    begin
      int n;
      n = 0;
      while (lcd_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("ready_rise", lcd_ready, 1'b1);
      check("ready_time", cyc - last, EH + CW);
    end
  endtask

  task automatic run_update(input logic [3:0] s, input logic m, input int gap, input int prev,
                            input bit mid, input logic [3:0] ns, input logic nm, output int last);
    logic [8:0] rd;
    int r, w, p;
    p = prev;
    for (int i = 0; i < 17; i++) begin
      get_byte(rd, r, w);
      check($sformatf("upd_b%0d", i), rd, upd_byte(i, s, m));
      check($sformatf("upd_w%0d", i), w, EH);
      check($sformatf("upd_gap%0d", i), r - p, (i == 0) ? gap : 1 + EH + CW);
      check($sformatf("upd_busy%0d", i), busy, 1'b1);
      p = r;
      if (mid && i == 5) begin
        seq_bits = ns;
        match_in = nm;
      end
    end
    last = p;
  endtask

  task automatic wait_idle(input int last);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", busy, 1'b0);
    check("idle_time", cyc - last, EH + CW);
    check("idle_bus", {lcd_rs, lcd_data}, 9'h000);
  endtask

  initial begin
    int last, c, rises, busy_seen;
    logic prev_e;

    seq_bits = 4'b0001;
    match_in = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_e", lcd_e, 1'b0);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_rw", lcd_rw, 1'b0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_ready", lcd_ready, 1'b0);
    check("rst_busy", busy, 1'b1);

    rst_n = 1'b1;
    run_init(cyc, last);
    // First update is unconditional and follows two edges after ready
    run_update(4'b0001, 1'b0, 2 + EH + CW, last, 1'b0, 4'b0, 1'b0, last);
    wait_idle(last);

    repeat (20) @(negedge clk);
    seq_bits = 4'b1010;
    match_in = 1'b1;
    c = cyc;
    run_update(4'b1010, 1'b1, 2, c, 1'b0, 4'b0, 1'b0, last);
    wait_idle(last);

    rises = 0; busy_seen = 0; prev_e = lcd_e;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (lcd_e === 1'b1 && prev_e !== 1'b1) rises++;
      if (busy !== 1'b0) busy_seen++;
      prev_e = lcd_e;
    end
    check("quiet_strobes", rises, 0);
    check("quiet_busy", busy_seen, 0);
    check("quiet_rw", lcd_rw, 1'b0);

    seq_bits = 4'b0110;
    match_in = 1'b1;
    c = cyc;
    run_update(4'b0110, 1'b1, 2, c, 1'b1, 4'b1111, 1'b0, last);
    run_update(4'b1111, 1'b0, 2 + EH + CW, last, 1'b0, 4'b0, 1'b0, last);
    wait_idle(last);

    seq_bits = 4'b0000;
    match_in = 1'b0;
    c = 0;
    while (lcd_e !== 1'b1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("pre_reset_e", lcd_e, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_e", lcd_e, 1'b0);
    check("midrst_ready", lcd_ready, 1'b0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_bus", {lcd_rs, lcd_data}, 9'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init(cyc, last);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/lcd_seq_display.md
Name: lcd_seq_display

Overview:
- Downstream consumer of the sequence generator/detector's display outputs: the 4 generated bits and the match flag.
- Drives an HD44780-compatible 16x2 character LCD over an 8-bit parallel bus.
- Performs the power-up init sequence, then rewrites both lines whenever the displayed inputs change.
- Line 1 shows "SEQ:bbbb"; line 2 shows "DET:YES" or "DET:NO ".

Parameters:
PWR_UP_CYC, 1000000, idle cycles after reset before the first command (20 ms at 50 MHz)
E_HIGH_CYC, 25, cycles lcd_e is held high per write (500 ns)
CMD_WAIT_CYC, 2500, post-strobe wait for ordinary commands and data (50 us)
CLR_WAIT_CYC, 100000, post-strobe wait after the clear command 0x01 (2 ms)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
seq_bits  input  4  generated pattern; seq_bits[0] is the first generated bit
match_in  input  1  detector result, 1 = sequence matched
lcd_rs  output  1  register select: 0 = command, 1 = data
lcd_rw  output  1  read/write select, constant 0 (write only)
lcd_e  output  1  enable strobe
lcd_data  output  8  data bus
lcd_ready  output  1  1 once the init sequence has completed
busy  output  1  1 while in power-up, init or update

Behaviour:
- Reset (rst_n low at a clock edge) forces:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, lcd_ready=0, busy=1.
  - FSM to PWRUP, all counters to 0, snapshot marked invalid.
- Reset asserted mid-write drops lcd_e on that same edge; after release the full power-up wait restarts.
- Top FSM states:
  - PWRUP: count PWR_UP_CYC cycles, then go to INIT.
  - INIT: write commands 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, with rs=0 for all. Then set lcd_ready=1 and go to IDLE.
  - IDLE: busy=0. Enter UPD on the next edge when the snapshot is invalid or {match_in, seq_bits} differs from the snapshot.
  - UPD: on entry, capture {match_in, seq_bits} into the snapshot (snapshot becomes valid). Then write the 17-byte sequence below and return to IDLE.
- UPD byte sequence:
  - Command 0x80.
  - Data 'S','E','Q',':'.
  - Four bit characters, left to right: seq_bits[0], [1], [2], [3]; '0'=0x30, '1'=0x31.
  - Command 0xC0.
  - Data 'D','E','T',':', then "YES" if match_in else "NO " (0x4E, 0x4F, 0x20).
- Write sub-FSM, per byte:
  - SETUP: 1 cycle with rs and data driven, e=0.
  - EHI: E_HIGH_CYC cycles with e=1.
  - WAIT: CMD_WAIT_CYC cycles with e=0, or CLR_WAIT_CYC cycles for 0x01.
  - rs and data stay stable from SETUP through the end of WAIT.
  - One byte occupies 1+E_HIGH_CYC+WAIT cycles exactly; the next SETUP follows immediately.
- lcd_data returns to 8'h00 and rs to 0 in IDLE.
- Input changes during UPD are ignored until UPD completes. Because the snapshot differs, a second update then starts on the following edge. Only the latest values are ever displayed; there is no queueing.
- An input change that reverts before IDLE samples it triggers no update.
- The first update after init is unconditional (snapshot invalid), even if the inputs are all zero.
- The counter is wide enough for max(PWR_UP_CYC, CLR_WAIT_CYC); there is no wrap-around within a count.

Test Plan (PWR_UP_CYC=100, E_HIGH_CYC=3, CMD_WAIT_CYC=10, CLR_WAIT_CYC=40):
- Init sequence:
  - Stimulus: release rst_n.
  - Response: first e rise 101 cycles after release; seven e pulses, each 3 cycles wide, with data 38,38,38,38,0C,01,06 and rs=0.
  - Response: the gap after 01 is 40 cycles; lcd_ready rises after the last wait.
- First update:
  - Stimulus: seq_bits=4'b0001, match_in=0 during init.
  - Response: immediate update writes 80,'S','E','Q',':',31,30,30,30,C0,'D','E','T',':',4E,4F,20; busy=0 afterwards.
- Change in IDLE:
  - Stimulus: seq_bits=4'b1010, match_in=1.
  - Response: update shows "SEQ:0101" and "DET:YES" (59,45,53); exactly 17 strobes of 14 cycles each.
- Change mid-update:
  - Stimulus: change seq_bits during byte 6 of an update.
  - Response: the current update completes with the old values; a second update starts 1 cycle after IDLE is entered and shows the new values.
- No-change case:
  - Stimulus: hold inputs constant for 1000 cycles in IDLE.
  - Response: no e pulses; busy stays 0.
- Reset mid-write:
  - Stimulus: assert rst_n low while e=1.
  - Response: e=0, lcd_ready=0 and busy=1 on the next edge; the full init sequence is repeated after release.
